// File: rtl/shift_frame_sequencer.sv
// Sends a multi-byte frame through an 8-bit serial shift register, MSB byte first,
// pacing it with a divided strobe and finishing with a storage-latch pulse.
module shift_frame_sequencer #(
  parameter int NUM_BYTES = 2,
  parameter int CLK_DIV   = 4,
  parameter int LATCH_STB = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_refresh_stb,
  input  logic [8*NUM_BYTES-1:0] i_frame_data,
  output logic                   o_busy,
  output logic                   o_done_stb,
  output logic                   o_sr_clk_stb,
  output logic                   o_sr_start_stb,
  output logic [7:0]             o_sr_data,
  input  logic                   i_sr_busy,
  output logic                   o_latch
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int LAT_W = (LATCH_STB > 1) ? $clog2(LATCH_STB) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NUM_BYTES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATCH_STB - 1);
  localparam logic [1:0]       WAIT_LAST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_LATCH     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                 r_state;
  logic [DIV_W-1:0]       r_div;
  logic [IDX_W-1:0]       r_idx;
  logic [8*NUM_BYTES-1:0] r_buf;
  logic                   r_pend;
  logic [1:0]             r_wait;
  logic [LAT_W-1:0]       r_lcnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_clk_stb;
  logic                   r_start;
  logic [7:0]             r_sr_data;
  logic                   r_latch;

  state_t                 w_state_nxt;
  logic [DIV_W-1:0]       w_div_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [8*NUM_BYTES-1:0] w_buf_nxt;
  logic                   w_pend_nxt;
  logic [1:0]             w_wait_nxt;
  logic [LAT_W-1:0]       w_lcnt_nxt;
  logic                   w_stb;

  assign w_stb     = (r_div == DIV_LAST);
  assign w_div_nxt = w_stb ? '0 : r_div + DIV_W'(1);

  // Next-state, byte index, frame capture and pending-request logic
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    w_pend_nxt  = r_pend;
    w_wait_nxt  = r_wait;
    w_lcnt_nxt  = r_lcnt;
    case (r_state)
      S_IDLE: begin
        if (i_refresh_stb || r_pend) begin
          w_buf_nxt   = i_frame_data;
          w_idx_nxt   = IDX_FIRST;
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_wait_nxt  = 2'd0;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A start the shift register never acknowledges is simply re-issued
        if (i_sr_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = S_START;
        end else begin
          w_wait_nxt = r_wait + 2'd1;
        end
      end
      S_WAIT_DONE: begin
        if (i_sr_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_idx == '0) begin
          w_lcnt_nxt  = '0;
          w_state_nxt = S_LATCH;
        end else begin
          w_idx_nxt   = r_idx - IDX_W'(1);
          w_state_nxt = S_START;
        end
      end
      S_LATCH: begin
        if (!w_stb) begin
          w_state_nxt = S_LATCH;
        end else if (r_lcnt == LAT_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_lcnt_nxt = r_lcnt + LAT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if ((r_state != S_IDLE) && i_refresh_stb) begin
      w_pend_nxt = 1'b1;
    end else begin
      w_pend_nxt = w_pend_nxt;
    end
  end

  // State, datapath and registered outputs decoded from the next state
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_idx     <= '0;
      r_buf     <= '0;
      r_pend    <= 1'b0;
      r_wait    <= 2'd0;
      r_lcnt    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clk_stb <= 1'b0;
      r_start   <= 1'b0;
      r_sr_data <= 8'h00;
      r_latch   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_idx     <= w_idx_nxt;
      r_buf     <= w_buf_nxt;
      r_pend    <= w_pend_nxt;
      r_wait    <= w_wait_nxt;
      r_lcnt    <= w_lcnt_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      r_clk_stb <= (w_div_nxt == DIV_LAST);
      r_start   <= (w_state_nxt == S_START);
      r_sr_data <= w_buf_nxt[{w_idx_nxt, 3'b000} +: 8];
      r_latch   <= (w_state_nxt == S_LATCH);
    end
  end

  assign o_busy         = r_busy;
  assign o_done_stb     = r_done;
  assign o_sr_clk_stb   = r_clk_stb;
  assign o_sr_start_stb = r_start;
  assign o_sr_data      = r_sr_data;
  assign o_latch        = r_latch;

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Directed bench for shift_frame_sequencer with a behavioural 8-bit shift register
// model that records each byte shifted out MSB first.
module tb_shift_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        refresh = 1'b0;
  logic [15:0] frame = 16'h0000;
  logic        busy, done_stb, sr_clk_stb, sr_start, latch;
  logic [7:0]  sr_data;

  logic        m_busy = 1'b0;
  logic [7:0]  m_sh = 8'h00;
  logic [7:0]  m_rx = 8'h00;
  logic [2:0]  m_cnt = 3'd0;
  logic        stub_low = 1'b0;
  logic [7:0]  got [0:63];
  int          n_bytes = 0;

  int n_start = 0, n_done = 0, n_lat_stb = 0, n_lat_bad = 0, n_lat_cyc = 0;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  shift_frame_sequencer #(.NUM_BYTES(2), .CLK_DIV(4), .LATCH_STB(2)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_refresh_stb  (refresh),
    .i_frame_data   (frame),
    .o_busy         (busy),
    .o_done_stb     (done_stb),
    .o_sr_clk_stb   (sr_clk_stb),
    .o_sr_start_stb (sr_start),
    .o_sr_data      (sr_data),
    .i_sr_busy      (m_busy),
    .o_latch        (latch)
  );

  // Shift register model: load on start, shift one bit per strobe, busy for 8 strobes
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 3'd0;
    end else if (stub_low) begin
      m_busy <= 1'b0;
    end else if (!m_busy && sr_start) begin
      m_busy <= 1'b1;
      m_sh   <= sr_data;
      m_cnt  <= 3'd0;
    end else if (m_busy && sr_clk_stb) begin
      m_rx  <= {m_rx[6:0], m_sh[7]};
      m_sh  <= {m_sh[6:0], 1'b0};
      m_cnt <= m_cnt + 3'd1;
      if (m_cnt == 3'd7) begin
        m_busy <= 1'b0;
        got[n_bytes[5:0]] <= {m_rx[6:0], m_sh[7]};
        n_bytes <= n_bytes + 1;
      end
    end
  end

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    n_start   += int'(sr_start);
    n_done    += int'(done_stb);
    n_lat_stb += int'(latch && sr_clk_stb);
    n_lat_bad += int'(latch && m_busy);
    n_lat_cyc += int'(latch);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output int busy_low);
    int k;
    k = 0;
    busy_low = 0;
    do begin
      @(negedge clk);
      k++;
      if (!busy) busy_low++;
    end while (done_stb !== 1'b1 && k < budget);
    check_val("done_seen", 32'(done_stb), 32'd1);
  endtask

  task automatic request(input logic [15:0] data);
    frame   = data;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  initial begin
    int s_start, s_done, s_lat, s_cyc, b0, bl, ns, nst, nt;
    int t [0:2];
    logic [11:0] stb_vec;

    repeat (3) @(negedge clk);
    check_val("reset_outputs", 32'({busy, done_stb, sr_clk_stb, sr_start, latch, sr_data}), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      stb_vec[k] = sr_clk_stb;
    end
    check_val("div_after_reset", 32'(stb_vec), 32'h444);

    // Single frame, input changed right after the request
    s_start = n_start; s_done = n_done; s_lat = n_lat_stb; b0 = n_bytes;
    check_val("idle_busy", 32'(busy), 32'd0);
    request(16'hA55A);
    frame = 16'hFFFF;
    check_val("busy_after_req", 32'(busy), 32'd1);
    wait_done(600, bl);
    check_val("busy_held", 32'(bl), 32'd0);
    check_val("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    check_val("busy_after_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_val("f1_nbytes", 32'(n_bytes - b0), 32'd2);
    check_val("f1_byte0", 32'(got[b0]), 32'hA5);
    check_val("f1_byte1", 32'(got[b0 + 1]), 32'h5A);
    check_val("f1_starts", 32'(n_start - s_start), 32'd2);
    check_val("f1_dones", 32'(n_done - s_done), 32'd1);
    check_val("f1_latch_stb", 32'(n_lat_stb - s_lat), 32'd2);

    // Three requests during a frame merge into one extra frame
    s_start = n_start; s_done = n_done; b0 = n_bytes;
    request(16'hC33C);
    for (int r = 0; r < 3; r++) begin
      repeat (8) @(negedge clk);
      request(16'h7777);
    end
    frame = 16'h1234;
    wait_done(600, bl);
    @(negedge clk);
    check_val("gap_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check_val("restart_start", 32'(sr_start), 32'd1);
    wait_done(600, bl);
    repeat (60) @(negedge clk);
    check_val("pend_starts", 32'(n_start - s_start), 32'd4);
    check_val("pend_dones", 32'(n_done - s_done), 32'd2);
    check_val("pend_bytes", 32'({got[b0], got[b0 + 1], got[b0 + 2], got[b0 + 3]}), 32'hC33C1234);

    // Request landing in the DONE cycle
    b0 = n_bytes;
    request(16'hBEEF);
    wait_done(600, bl);
    frame = 16'h0102;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done(600, bl);
    repeat (3) @(negedge clk);
    check_val("donereq_bytes", 32'({got[b0], got[b0 + 1], got[b0 + 2], got[b0 + 3]}), 32'hBEEF0102);

    // Reset while the second byte is shifting, with a request pending
    request(16'h0FF0);
    ns = 1;
    for (int k = 0; k < 200 && ns < 2; k++) begin
      @(negedge clk);
      if (sr_start) ns++;
    end
    check_val("second_byte_reached", 32'(ns), 32'd2);
    repeat (5) @(negedge clk);
    request(16'h5555);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midreset_outputs", 32'({busy, done_stb, sr_start, latch, sr_data}), 32'd0);
    rst_n = 1'b1;
    s_start = n_start; s_done = n_done; s_cyc = n_lat_cyc;
    repeat (20) @(negedge clk);
    check_val("midreset_no_start", 32'(n_start - s_start), 32'd0);
    check_val("midreset_no_done", 32'(n_done - s_done), 32'd0);
    check_val("midreset_no_latch", 32'(n_lat_cyc - s_cyc), 32'd0);
    b0 = n_bytes;
    request(16'h6699);
    wait_done(600, bl);
    repeat (3) @(negedge clk);
    check_val("post_reset_bytes", 32'({got[b0], got[b0 + 1]}), 32'h6699);

    // Shift register never acknowledges: start retries every 5 cycles
    stub_low = 1'b1;
    b0 = n_bytes;
    frame = 16'h8137;
    refresh = 1'b1;
    ns = 0; nst = 0; bl = 0; nt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      refresh = 1'b0;
      if (sr_start) begin
        ns++;
        if (nt < 3) begin
          t[nt] = k;
          nt++;
        end
      end
      if (sr_clk_stb) nst++;
      if (!busy) bl++;
    end
    check_val("stub_starts", 32'(ns), 32'd8);
    check_val("stub_period_a", 32'(t[1] - t[0]), 32'd5);
    check_val("stub_period_b", 32'(t[2] - t[1]), 32'd5);
    check_val("stub_busy", 32'(bl), 32'd0);
    check_val("div_continuous", 32'(nst), 32'd10);
    stub_low = 1'b0;
    wait_done(600, bl);
    repeat (3) @(negedge clk);
    check_val("stub_bytes", 32'({got[b0], got[b0 + 1]}), 32'h8137);

    check_val("latch_vs_busy", 32'(n_lat_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
